// File: rtl/logic_debouncer.sv
// Two-flop synchronizer followed by a four-state debounce FSM. A new input level
// is accepted only after DEBOUNCE_CYCLES consecutive synchronized samples at that level.
module logic_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW    = 2'd3;

  logic          sync0;
  logic          s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync0 <= RESET_LEVEL;
      s     <= RESET_LEVEL;
      out   <= RESET_LEVEL;
      state <= RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync0 <= in;
      s     <= sync0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          // A single contrary sample drops back to the old stable level.
          if (!s) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= STABLE_HIGH;
            out   <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= STABLE_LOW;
            out   <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Decoded from the state register, so still free of any path from in or rstn.
  assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_logic_debouncer.sv
// Bench for logic_debouncer: two instances (reset level 0 and 1) share the stimulus;
// a sample-window model is compared every cycle, plus directed literal checks.
module tb_logic_debouncer;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rstn_d;
  logic in_d;
  logic out0, rise0, fall0, busy0;
  logic out1, rise1, fall1, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic_debouncer #(.DEBOUNCE_CYCLES(D), .RESET_LEVEL(1'b0)) dut0 (
    .clk(clk), .rstn(rstn_d), .in(in_d),
    .out(out0), .rise(rise0), .fall(fall0), .busy(busy0)
  );

  logic_debouncer #(.DEBOUNCE_CYCLES(D), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .rstn(rstn_d), .in(in_d),
    .out(out1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FSM sees the input two edges late; the level flips once the last
  // D samples since reset all disagree with the current level.
  logic         p0[2], p1[2];
  logic [D-1:0] win[2];
  int           nwin[2];
  logic         m_out[2], m_rise[2], m_fall[2], m_busy[2];
  logic         model_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic lvl;
      logic smp;
      lvl = (i == 1);
      if (!rstn_d) begin
        p0[i] = lvl;  p1[i] = lvl;
        win[i] = '0;  nwin[i] = 0;
        m_out[i] = lvl; m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_busy[i] = 1'b0;
      end else begin
        smp = p1[i];
        p1[i] = p0[i];
        p0[i] = in_d;
        win[i] = {win[i][D-2:0], smp};
        if (nwin[i] < D) nwin[i]++;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (nwin[i] == D && win[i] == {D{~m_out[i]}}) begin
          m_out[i] = ~m_out[i];
          if (m_out[i]) m_rise[i] = 1'b1;
          else          m_fall[i] = 1'b1;
        end
        m_busy[i] = (nwin[i] > 0) && (win[i][0] != m_out[i]);
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_out0",  out0,  m_out[0]);
      check("model_rise0", rise0, m_rise[0]);
      check("model_fall0", fall0, m_fall[0]);
      check("model_busy0", busy0, m_busy[0]);
      check("model_out1",  out1,  m_out[1]);
      check("model_rise1", rise1, m_rise[1]);
      check("model_fall1", fall1, m_fall[1]);
      check("model_busy1", busy1, m_busy[1]);
    end
  end

  initial begin
    logic pat[9];
    int   nr, rk, run_left;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset held for three edges with the input already high.
    rstn_d = 1'b0;
    in_d   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_out0",  out0,  1'b0);
      check("rst_rise0", rise0, 1'b0);
      check("rst_fall0", fall0, 1'b0);
      check("rst_busy0", busy0, 1'b0);
      check("rst_out1",  out1,  1'b1);
    end
    rstn_d = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rel_rise0", rise0, logic'(k == 5));
      check("rel_out0",  out0,  logic'(k >= 5));
      check("rel_busy0", busy0, logic'(k >= 2 && k <= 4));
      check("rel_rise1", rise1, 1'b0);
    end

    // Clean falling edge.
    in_d = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fall_pulse0", fall0, logic'(k == 5));
      check("fall_out0",   out0,  logic'(k < 5));
      check("fall_busy0",  busy0, logic'(k >= 2 && k <= 4));
      check("fall_rise0",  rise0, 1'b0);
    end

    // Three-cycle glitch is rejected.
    in_d = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("gl_out0",  out0,  1'b0);
      check("gl_rise0", rise0, 1'b0);
      check("gl_busy0", busy0, logic'(k >= 2 && k <= 4));
      in_d = logic'(k + 1 < 3);
    end

    // Bounce then settle: one rise, five edges after the final run of ones starts.
    nr = 0;
    rk = -1;
    in_d = pat[0];
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (rise0 === 1'b1) begin
        nr++;
        rk = k;
      end
      in_d = (k + 1 < 9) ? pat[k+1] : 1'b1;
    end
    check("bounce_nrise", nr, 1);
    check("bounce_edge",  rk, 10);

    // Reset mid-qualification, reset level 0.
    in_d = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_mid_out0", out0, 1'b0);
    in_d = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_busy0", busy0, 1'b1);
    rstn_d = 1'b0;
    @(negedge clk);
    check("mid_rst_busy0", busy0, 1'b0);
    check("mid_rst_out0",  out0,  1'b0);
    check("mid_rst_rise0", rise0, 1'b0);
    check("mid_rst_out1",  out1,  1'b1);
    rstn_d = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("mid_rel_rise0", rise0, logic'(k == 5));
    end

    // Reset mid-qualification, reset level 1.
    in_d = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy1", busy1, 1'b1);
    rstn_d = 1'b0;
    @(negedge clk);
    check("mid_rst_out1b",  out1,  1'b1);
    check("mid_rst_busy1",  busy1, 1'b0);
    check("mid_rst_fall1",  fall1, 1'b0);
    check("mid_rst_out0b",  out0,  1'b0);
    rstn_d = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("mid_rel_fall1", fall1, logic'(k == 5));
    end

    // Randomized runs of varying length with occasional resets.
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (run_left == 0) begin
        in_d     = logic'($urandom_range(0, 1));
        run_left = $urandom_range(1, 7);
      end
      run_left--;
      rstn_d = ($urandom_range(0, 149) != 0);
    end
    rstn_d = 1'b1;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
